// File: rtl/hello_caller.sv
// hello_caller: queues upstream arguments and issues them one at a time as
// req_hello/arg_hello calls to a downstream callee, waiting for ack_hello.
//
// Optional feature: define HELLO_CALLER_TIMEOUT_EN to abandon a call after
// TIMEOUT cycles without ack_hello, raising the sticky err flag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid, in_data upstream argument offer
//   in_ready          queue not full (combinational from queue count)
//   req_hello         registered call request to the callee
//   arg_hello         registered call argument, stable while req_hello high
//   ack_hello         callee acknowledge
//   busy              queue non-empty or a call in progress
//   done_count        completed calls, 16-bit wrapping
//   err               sticky timeout flag (constant 0 without the macro)
module hello_caller #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_hello,
    output logic [WIDTH-1:0] arg_hello,
    input  logic             ack_hello,
    output logic             busy,
    output logic [15:0]      done_count,
    output logic             err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hello_caller: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("hello_caller: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [15:0]      done_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

`ifdef HELLO_CALLER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    // Queue status; a full queue refuses pushes even when a pop coincides
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (count != '0) || (state_q != IDLE);

    assign req_hello = req_q;
    assign arg_hello = arg_q;

    // Queue storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Queue pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Call FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            arg_q      <= '0;
            done_count <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            arg_q      <= arg_d;
            done_count <= done_d;
        end
    end

`ifdef HELLO_CALLER_TIMEOUT_EN
    // Timeout counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        arg_d   = arg_q;
        done_d  = done_count;
        pop     = 1'b0;
`ifdef HELLO_CALLER_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                // Head is read from registered queue state, so a push only
                // becomes visible as a request one cycle later
                if (count != '0) begin
                    req_d   = 1'b1;
                    arg_d   = mem[rd_ptr];
                    state_d = REQ;
`ifdef HELLO_CALLER_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            REQ: begin
                if (ack_hello) begin
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    done_d  = done_count + 16'd1;
                    state_d = DRAIN;
                end
`ifdef HELLO_CALLER_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    // Abandon the call: drop the entry without counting it
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            DRAIN: begin
                // Wait for the callee to release ack before the next call
                if (!ack_hello) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule
